// File: rtl/regfile_write_queue.sv
// Buffered register-file write-back queue: a small FIFO of {addr, data} writes drained one per cycle
// into a registered write port, with a combinational youngest-first bypass over pending writes.
module regfile_write_queue #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_stall,
    output logic                     wr_en,
    output logic [3:0]               wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    input  logic [3:0]               byp_addr,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]        addr_q [DEPTH];
    logic [3:0]        addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [3:0]        wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic push, pop;

    // Ready depends only on the registered count, so a same-cycle pop never frees a full queue.
    assign in_ready = rst_n && (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count_q != '0) && !rf_stall;

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        wr_en_d   = pop;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            wr_addr_d = addr_q[head_q];
            wr_data_d = data_q[head_q];
            head_d    = head_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            addr_q    <= addr_d;
            data_q    <= data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Slot gi of the bypass view is the (gi+1)-th youngest entry, i.e. tail-1-gi.
    logic [DEPTH-1:0]  fifo_hit;
    logic [DATA_W-1:0] slot_data [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_byp
        logic [PW-1:0] slot;
        assign slot          = tail_q - PW'(gi + 1);
        assign fifo_hit[gi]  = (CW'(gi) < count_q) && (addr_q[slot] == byp_addr);
        assign slot_data[gi] = data_q[slot];
    end

    // Lowest priority first so the youngest match overwrites older ones.
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (wr_en_q && (wr_addr_q == byp_addr)) begin
            byp_hit  = 1'b1;
            byp_data = wr_data_q;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (fifo_hit[i]) begin
                byp_hit  = 1'b1;
                byp_data = slot_data[i];
            end
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign count   = count_q;

endmodule

// File: tb/tb_regfile_write_queue.sv
// Directed self-checking bench for regfile_write_queue: reset, single write, back-pressure,
// bypass priority, output-stage bypass, wrap-around streaming and mid-operation reset.
module tb_regfile_write_queue;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_addr;
    logic [DATA_W-1:0] in_data;
    logic              rf_stall;
    logic              wr_en;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        byp_addr;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_data;
    logic [$clog2(DEPTH):0] count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_write_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_addr  (in_addr),
        .in_data  (in_data),
        .rf_stall (rf_stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .byp_addr (byp_addr),
        .byp_hit  (byp_hit),
        .byp_data (byp_data),
        .count    (count)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [3:0] a, input logic [DATA_W-1:0] d);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int  i;
        int  j;
        logic acc;
        logic seen;

        rst_n = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        rf_stall = 1'b0; byp_addr = '0;

        // Reset values
        repeat (2) tick();
        check("rst_wr_en",    32'(wr_en),    32'd0);
        check("rst_wr_addr",  32'(wr_addr),  32'd0);
        check("rst_wr_data",  32'(wr_data),  32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_byp_hit",  32'(byp_hit),  32'd0);
        check("rst_byp_data", 32'(byp_data), 32'd0);
        check("rst_count",    32'(count),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Single write: accepted at edge N, presented after edge N+1
        in_valid = 1'b1; in_addr = 4'd3; in_data = 16'h00AB;
        tick();
        in_valid = 1'b0;
        check("single_count1", 32'(count), 32'd1);
        check("single_wr_en0", 32'(wr_en), 32'd0);
        tick();
        check("single_wr_en",   32'(wr_en),   32'd1);
        check("single_wr_addr", 32'(wr_addr), 32'd3);
        check("single_wr_data", 32'(wr_data), 32'h00AB);
        check("single_count0",  32'(count),   32'd0);
        tick();
        check("single_wr_en_off", 32'(wr_en), 32'd0);

        // Back-pressure: fill under stall, fifth request held
        rf_stall = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; in_addr = 4'(k); in_data = 16'(k * 16'h11);
            tick();
        end
        in_valid = 1'b1; in_addr = 4'd5; in_data = 16'h0055;
        check("full_count", 32'(count),    32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        tick();
        check("full_held_count", 32'(count), 32'd4);
        rf_stall = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
            check($sformatf("drain%0d_en", k),   32'(wr_en),   32'd1);
            check($sformatf("drain%0d_addr", k), 32'(wr_addr), 32'(k));
            check($sformatf("drain%0d_data", k), 32'(wr_data), 32'(k * 16'h11));
        end
        tick();
        check("drain_done_en",    32'(wr_en), 32'd0);
        check("drain_done_count", 32'(count), 32'd0);

        // Bypass priority: youngest of duplicate addresses wins
        rf_stall = 1'b1;
        push_one(4'd7, 16'h000A);
        push_one(4'd7, 16'h000B);
        push_one(4'd2, 16'h000C);
        byp_addr = 4'd7; #1;
        check("byp7_hit",  32'(byp_hit),  32'd1);
        check("byp7_data", 32'(byp_data), 32'h000B);
        byp_addr = 4'd9; #1;
        check("byp9_hit",  32'(byp_hit),  32'd0);
        check("byp9_data", 32'(byp_data), 32'd0);
        byp_addr = 4'd2; #1;
        check("byp2_data", 32'(byp_data), 32'h000C);
        rf_stall = 1'b0;
        repeat (4) tick();
        check("byp_drain_count", 32'(count), 32'd0);

        // Output-stage bypass
        byp_addr = 4'd6;
        push_one(4'd6, 16'h0066);
        check("obyp_fifo_hit", 32'(byp_hit), 32'd1);
        tick();
        check("obyp_wr_en", 32'(wr_en),    32'd1);
        check("obyp_hit",   32'(byp_hit),  32'd1);
        check("obyp_data",  32'(byp_data), 32'h0066);
        tick();
        check("obyp_gone_hit",  32'(byp_hit),  32'd0);
        check("obyp_gone_data", 32'(byp_data), 32'd0);

        // Streaming with wrap-around
        i = 0; j = 0;
        for (int cyc = 0; cyc < 40 && j < 10; cyc++) begin
            in_valid = (i < 10);
            in_addr  = 4'(i);
            in_data  = 16'(i * 3);
            acc = in_valid && in_ready;
            if (in_valid) check($sformatf("stream_ready%0d", i), 32'(in_ready), 32'd1);
            tick();
            if (acc) i++;
            if (wr_en) begin
                check($sformatf("stream%0d_addr", j), 32'(wr_addr), 32'(j));
                check($sformatf("stream%0d_data", j), 32'(wr_data), 32'(j * 3));
                j++;
            end
        end
        in_valid = 1'b0;
        check("stream_all_out", 32'(j), 32'd10);

        // Reset mid-operation discards queued writes
        tick();
        rf_stall = 1'b1;
        push_one(4'd8,  16'h0808);
        push_one(4'd9,  16'h0909);
        push_one(4'd10, 16'h0A0A);
        byp_addr = 4'd9; #1;
        check("mid_count", 32'(count),   32'd3);
        check("mid_hit",   32'(byp_hit), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count),    32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_wr_en", 32'(wr_en),    32'd0);
        check("mid_rst_hit",   32'(byp_hit),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rf_stall = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            tick();
            if (wr_en) seen = 1'b1;
        end
        check("mid_rst_no_write", 32'(seen),     32'd0);
        check("mid_rst_ready1",   32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
